// File: rtl/reaction_stats.sv
// ---------------------------------------------------------------------------
// reaction_stats
//
// Running statistics over the reaction timer's per-trial results. Keeps the
// best and worst valid time since the last clear, and the mean of the last
// min(TrialCount, DEPTH) valid times. Also counts valid, cheat and slow trials.
// Runs in the millisecond clock domain.
//
// Each valid trial runs through this sequence:
//   UPDATE (1 cycle) -> DIVIDE (one cycle per dividend bit) -> DONE (1 cycle)
// AvgTime and a one-cycle StatsValid pulse are registered when DONE ends.
//
// Optional build macro: REACTION_STATS_ROUND_EN
//   When defined, the average is rounded half-up instead of truncated.
//   The dividend gains one bit, so the result arrives one cycle later.
//
// Ports:
//   Clk          millisecond clock
//   Rst          synchronous active-high reset
//   Clear        synchronous statistics clear (same effect as Rst)
//   ResultValid  one-cycle strobe: a trial finished
//   ResultTime   reaction time in ms
//   ResultCheat  trial was a cheat
//   ResultSlow   trial timed out
//   BestTime     minimum valid time since clear (all ones when none)
//   WorstTime    maximum valid time since clear
//   AvgTime      windowed mean of valid times
//   TrialCount   valid trials since clear (saturating)
//   CheatCount   cheat trials since clear (saturating)
//   SlowCount    slow trials since clear (saturating)
//   StatsValid   one-cycle pulse: all statistics updated
//   Busy         an update is in progress
//   Overrun      sticky: a ResultValid arrived while Busy
// ---------------------------------------------------------------------------
module reaction_stats #(
    parameter int TIME_W     = 10,
    parameter int LOG2_DEPTH = 3,
    parameter int CNT_W      = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Clear,
    input  logic              ResultValid,
    input  logic [TIME_W-1:0] ResultTime,
    input  logic              ResultCheat,
    input  logic              ResultSlow,
    output logic [TIME_W-1:0] BestTime,
    output logic [TIME_W-1:0] WorstTime,
    output logic [TIME_W-1:0] AvgTime,
    output logic [CNT_W-1:0]  TrialCount,
    output logic [CNT_W-1:0]  CheatCount,
    output logic [CNT_W-1:0]  SlowCount,
    output logic              StatsValid,
    output logic              Busy,
    output logic              Overrun
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = TIME_W + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;
    // The remainder is always below fill, which is at most DEPTH.
    localparam int REM_W  = LOG2_DEPTH + 1;
`ifdef REACTION_STATS_ROUND_EN
    localparam int DVD_W  = SUM_W + 1;
`else
    localparam int DVD_W  = SUM_W;
`endif
    localparam int DCNT_W = $clog2(DVD_W);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] UPDATE = 2'd1;
    localparam logic [1:0] DIVIDE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]            state_reg;
    logic [TIME_W-1:0]     t_reg;
    logic [SUM_W-1:0]      sum_reg;
    logic [FILL_W-1:0]     fill_reg;
    logic [LOG2_DEPTH-1:0] wptr_reg;
    logic [TIME_W-1:0]     rd_data_reg;
    logic [DVD_W-1:0]      dvd_reg;
    logic [REM_W-1:0]      rem_reg;
    logic [DCNT_W-1:0]     div_cnt_reg;

    // Window of the most recent valid times. This block RAM has a
    // registered read port.
    logic [TIME_W-1:0]     window [DEPTH];

    logic                  full;
    logic [TIME_W-1:0]     old_time;
    logic [SUM_W-1:0]      sum_next;
    logic [FILL_W-1:0]     fill_next;
    logic [DVD_W-1:0]      dvd_init;
    logic [REM_W:0]        rem_shift;
    logic [REM_W:0]        fill_ext;
    logic                  rem_ge;

    // wptr only moves in UPDATE. The window is only written in UPDATE.
    // So while IDLE, rd_data_reg already holds the entry that is about
    // to be overwritten.
    always_ff @(posedge Clk) begin
        if (state_reg == UPDATE) begin
            window[wptr_reg] <= t_reg;
        end
        rd_data_reg <= window[wptr_reg];
    end

    always_comb begin
        full      = (fill_reg == FILL_W'(DEPTH));
        old_time  = full ? rd_data_reg : '0;
        // Intermediate wrap is harmless: the final sum always fits SUM_W.
        sum_next  = sum_reg + SUM_W'(t_reg) - SUM_W'(old_time);
        fill_next = full ? fill_reg : fill_reg + 1'b1;
`ifdef REACTION_STATS_ROUND_EN
        dvd_init  = DVD_W'(sum_next) + DVD_W'(fill_next >> 1);
`else
        dvd_init  = DVD_W'(sum_next);
`endif
        // One restoring-division step. The quotient bits shift into the
        // dividend register from the right.
        rem_shift = {rem_reg, dvd_reg[DVD_W-1]};
        fill_ext  = {1'b0, fill_reg};
        rem_ge    = (rem_shift >= fill_ext);
    end

    assign Busy = (state_reg != IDLE);

    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            state_reg   <= IDLE;
            t_reg       <= '0;
            sum_reg     <= '0;
            fill_reg    <= '0;
            wptr_reg    <= '0;
            dvd_reg     <= '0;
            rem_reg     <= '0;
            div_cnt_reg <= '0;
            BestTime    <= '1;
            WorstTime   <= '0;
            AvgTime     <= '0;
            TrialCount  <= '0;
            CheatCount  <= '0;
            SlowCount   <= '0;
            StatsValid  <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            StatsValid <= 1'b0;
            if (ResultValid && state_reg != IDLE) begin
                Overrun <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (ResultValid) begin
                        if (ResultCheat) begin
                            if (CheatCount != '1) CheatCount <= CheatCount + 1'b1;
                        end else if (ResultSlow) begin
                            if (SlowCount != '1) SlowCount <= SlowCount + 1'b1;
                        end else begin
                            t_reg     <= ResultTime;
                            state_reg <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    sum_reg  <= sum_next;
                    fill_reg <= fill_next;
                    wptr_reg <= wptr_reg + 1'b1;
                    if (t_reg < BestTime)  BestTime  <= t_reg;
                    if (t_reg > WorstTime) WorstTime <= t_reg;
                    if (TrialCount != '1) TrialCount <= TrialCount + 1'b1;
                    dvd_reg     <= dvd_init;
                    rem_reg     <= '0;
                    div_cnt_reg <= '0;
                    state_reg   <= DIVIDE;
                end
                DIVIDE: begin
                    rem_reg     <= rem_ge ? REM_W'(rem_shift - fill_ext) : REM_W'(rem_shift);
                    dvd_reg     <= {dvd_reg[DVD_W-2:0], rem_ge};
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                    if (div_cnt_reg == DCNT_W'(DVD_W - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    AvgTime    <= dvd_reg[TIME_W-1:0];
                    StatsValid <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_stats.sv
module tb_reaction_stats;

    localparam int DEPTH = 8;
`ifdef REACTION_STATS_ROUND_EN
    localparam int LAT = 16;
    localparam int AVG_100_101 = 101;
`else
    localparam int LAT = 15;
    localparam int AVG_100_101 = 100;
`endif

    logic       Clk = 1'b0;
    logic       Rst, Clear, ResultValid, ResultCheat, ResultSlow;
    logic [9:0] ResultTime;
    logic [9:0] BestTime, WorstTime, AvgTime;
    logic [7:0] TrialCount, CheatCount, SlowCount;
    logic       StatsValid, Busy, Overrun;

    reaction_stats #(.TIME_W(10), .LOG2_DEPTH(3), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Clear(Clear),
        .ResultValid(ResultValid), .ResultTime(ResultTime),
        .ResultCheat(ResultCheat), .ResultSlow(ResultSlow),
        .BestTime(BestTime), .WorstTime(WorstTime), .AvgTime(AvgTime),
        .TrialCount(TrialCount), .CheatCount(CheatCount), .SlowCount(SlowCount),
        .StatsValid(StatsValid), .Busy(Busy), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue holding the last DEPTH valid times.
    int m_q[$];
    int m_best, m_worst, m_avg, m_trials, m_cheats, m_slows, m_overrun;

    function automatic void m_reset();
        m_q.delete();
        m_best = 1023; m_worst = 0; m_avg = 0;
        m_trials = 0; m_cheats = 0; m_slows = 0; m_overrun = 0;
    endfunction

    function automatic void m_valid(int t);
        int s;
        m_q.push_back(t);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
        s = 0;
        foreach (m_q[k]) s += m_q[k];
`ifdef REACTION_STATS_ROUND_EN
        m_avg = (s + m_q.size() / 2) / m_q.size();
`else
        m_avg = s / m_q.size();
`endif
        if (t < m_best)  m_best = t;
        if (t > m_worst) m_worst = t;
        if (m_trials < 255) m_trials++;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".avg"},     int'(AvgTime),    m_avg);
        check({tag, ".best"},    int'(BestTime),   m_best);
        check({tag, ".worst"},   int'(WorstTime),  m_worst);
        check({tag, ".trials"},  int'(TrialCount), m_trials);
        check({tag, ".cheats"},  int'(CheatCount), m_cheats);
        check({tag, ".slows"},   int'(SlowCount),  m_slows);
        check({tag, ".overrun"}, int'(Overrun),    m_overrun);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        m_reset();
        check_all("reset");
        check("reset.stats_valid", int'(StatsValid), 0);
        check("reset.busy", int'(Busy), 0);
    endtask

    // Drive one result strobe; returns at the negedge after it was sampled.
    task automatic strobe(int t, bit c, bit s);
        ResultTime  = 10'(t);
        ResultCheat = c;
        ResultSlow  = s;
        ResultValid = 1'b1;
        @(negedge Clk);
        ResultValid = 1'b0;
        ResultCheat = 1'b0;
        ResultSlow  = 1'b0;
    endtask

    // One complete trial. inject_at >= 0 drives an extra strobe that many
    // cycles into the update, and that strobe must be ignored.
    task automatic run_trial(string tag, int t, bit c, bit s, int inject_at);
        int n, busy, sv;
        strobe(t, c, s);
        n = 0; busy = 0; sv = 0;
        if (!c && !s) begin
            while (!StatsValid && n < 100) begin
                if (Busy) busy++;
                if (n == inject_at) begin
                    ResultTime  = 10'($urandom_range(0, 1023));
                    ResultCheat = 1'($urandom_range(0, 1));
                    ResultSlow  = 1'($urandom_range(0, 1));
                    ResultValid = 1'b1;
                    m_overrun   = 1;
                end
                @(negedge Clk);
                ResultValid = 1'b0; ResultCheat = 1'b0; ResultSlow = 1'b0;
                n++;
            end
            m_valid(t);
            check({tag, ".latency"}, n, LAT);
            check({tag, ".busy_cycles"}, busy, LAT);
        end else begin
            if (c) begin
                if (m_cheats < 255) m_cheats++;
            end else begin
                if (m_slows < 255) m_slows++;
            end
            repeat (LAT + 2) begin
                if (StatsValid) sv++;
                if (Busy) busy++;
                @(negedge Clk);
            end
            check({tag, ".no_stats_valid"}, sv, 0);
            check({tag, ".no_busy"}, busy, 0);
        end
        check_all(tag);
        $display("[TB] %s t=%0d cheat=%0d slow=%0d -> avg=%0d best=%0d worst=%0d trials=%0d cheats=%0d slows=%0d ovr=%0d",
                 tag, t, c, s, AvgTime, BestTime, WorstTime, TrialCount, CheatCount, SlowCount, Overrun);
    endtask

    typedef struct {
        int t; bit c; bit s;
        int avg; int best; int worst; int trials; int cheats; int slows;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, sv;
        Rst = 1'b1; Clear = 1'b0; ResultValid = 1'b0;
        ResultCheat = 1'b0; ResultSlow = 1'b0; ResultTime = '0;

        vecs[0] = '{0,   1, 0, 0,   1023, 0,   0, 1, 0};
        vecs[1] = '{700, 0, 1, 0,   1023, 0,   0, 1, 1};
        vecs[2] = '{200, 0, 0, 200, 200,  200, 1, 1, 1};
        vecs[3] = '{300, 0, 0, 250, 200,  300, 2, 1, 1};
        vecs[4] = '{250, 0, 0, 250, 200,  300, 3, 1, 1};
        vecs[5] = '{5,   1, 1, 250, 200,  300, 3, 2, 1};

        do_reset();

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_trial("vec", vecs[i].t, vecs[i].c, vecs[i].s, -1);
            check("tbl.avg",    int'(AvgTime),    vecs[i].avg);
            check("tbl.best",   int'(BestTime),   vecs[i].best);
            check("tbl.worst",  int'(WorstTime),  vecs[i].worst);
            check("tbl.trials", int'(TrialCount), vecs[i].trials);
            check("tbl.cheats", int'(CheatCount), vecs[i].cheats);
            check("tbl.slows",  int'(SlowCount),  vecs[i].slows);
            repeat (20) @(negedge Clk);
        end

        // Single trial: latency and average
        do_reset();
        run_trial("single", 500, 0, 0, -1);
        check("single.avg", int'(AvgTime), 500);

        // Full window and wrap-around
        do_reset();
        repeat (8) run_trial("fill", 100, 0, 0, -1);
        run_trial("wrap", 900, 0, 0, -1);
        check("wrap.avg",    int'(AvgTime),    200);
        check("wrap.best",   int'(BestTime),   100);
        check("wrap.worst",  int'(WorstTime),  900);
        check("wrap.trials", int'(TrialCount), 9);

        // Strobe while busy is ignored and sets Overrun
        run_trial("overrun", 400, 0, 0, 5);
        check("overrun.flag",   int'(Overrun),    1);
        check("overrun.trials", int'(TrialCount), 10);

        // Clear in the middle of DIVIDE
        strobe(300, 0, 0);
        repeat (5) @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        m_reset();
        check_all("clear_mid");
        check("clear_mid.busy", int'(Busy), 0);
        sv = 0;
        repeat (20) begin
            if (StatsValid) sv++;
            @(negedge Clk);
        end
        check("clear_mid.no_stats_valid", sv, 0);
        $display("[TB] clear mid-divide -> trials=%0d best=%0d ovr=%0d", TrialCount, BestTime, Overrun);

        // Clear wins over a simultaneous valid strobe
        Clear = 1'b1;
        strobe(123, 0, 0);
        Clear = 1'b0;
        check("clear_win.busy", int'(Busy), 0);
        check_all("clear_win");

        // Rounding-sensitive pair
        run_trial("pair", 100, 0, 0, -1);
        run_trial("pair", 101, 0, 0, -1);
        check("pair.avg", int'(AvgTime), AVG_100_101);

        // Cheat counter saturation (strobe held for 260 cycles)
        do_reset();
        ResultCheat = 1'b1; ResultValid = 1'b1; ResultTime = '0;
        n = 0;
        repeat (260) begin
            @(negedge Clk);
            if (m_cheats < 255) m_cheats++;
            n++;
        end
        ResultValid = 1'b0; ResultCheat = 1'b0;
        check("sat.cheats", int'(CheatCount), 255);
        check_all("sat");
        $display("[TB] saturation after %0d cheat strobes -> cheats=%0d", n, CheatCount);

        // Randomized trials against the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int r, t, inj;
            bit c, s;
            r = $urandom_range(0, 9);
            t = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 1023);
            c = (r == 0 || r == 2);
            s = (r == 1 || r == 2);
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 13) : -1;
            run_trial("rand", t, c, s, inj);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reaction_stats.md
Name: reaction_stats

Overview:
- Downstream consumer of the reaction timer's per-trial result.
- Keeps running statistics over a sliding window of the last DEPTH valid trials: best, worst and average reaction time, plus trial, cheat and slow counters.
- Outputs are exported for the display and LED stages.
- Runs in the millisecond clock domain, the same domain as the timer.

Parameters:
- TIME_W, 10: width of a reaction time in ms.
- LOG2_DEPTH, 3: log2 of the window size. DEPTH = 2**LOG2_DEPTH; legal range for LOG2_DEPTH is 1..6.
- CNT_W, 8: width of the trial, cheat and slow counters.

Ports:
- Clk  in  1  block clock (millisecond tick clock).
- Rst  in  1  reset; synchronous, active-high.
- Clear  in  1  synchronous statistics clear; same effect as Rst.
- ResultValid  in  1  one-cycle strobe: trial finished.
- ResultTime  in  TIME_W  reaction time in ms, sampled with ResultValid.
- ResultCheat  in  1  trial was a cheat; sampled with ResultValid.
- ResultSlow  in  1  trial timed out; sampled with ResultValid.
- BestTime  out  TIME_W  minimum valid time since clear.
- WorstTime  out  TIME_W  maximum valid time since clear.
- AvgTime  out  TIME_W  mean of the last min(TrialCount, DEPTH) valid times.
- TrialCount  out  CNT_W  valid trials since clear; saturating.
- CheatCount  out  CNT_W  cheat trials since clear; saturating.
- SlowCount  out  CNT_W  slow trials since clear; saturating.
- StatsValid  out  1  one-cycle pulse when all statistics are updated.
- Busy  out  1  high while an update is in progress.
- Overrun  out  1  sticky; a ResultValid arrived while Busy.

Behaviour:
- Reset values (Rst or Clear): BestTime = all ones, WorstTime = 0, AvgTime = 0, all counters 0, StatsValid = 0, Busy = 0, Overrun = 0. Window fill = 0, write pointer = 0, SUM = 0, state = IDLE.
- Clear has identical effect to Rst. It aborts any state. Clear wins over a simultaneous ResultValid.
- Internal storage:
  - Window RAM: DEPTH x TIME_W.
  - Running SUM: SUM_W = TIME_W + LOG2_DEPTH bits.
  - Fill: 0..DEPTH.
- Trial classification, evaluated only in IDLE when ResultValid = 1:
  - ResultCheat = 1: CheatCount++ (saturating at all ones). Nothing else changes, no StatsValid, stay in IDLE. Cheat takes priority if Cheat and Slow are both set.
  - ResultSlow = 1 (Cheat = 0): SlowCount++ (saturating). Nothing else changes, no StatsValid.
  - Otherwise the trial is valid: capture ResultTime and go to UPDATE.
- FSM states:
  - IDLE: Busy = 0. Handles trial classification as above.
  - UPDATE (1 cycle), Busy = 1:
    - SUM <= SUM + t - (fill == DEPTH ? window[wptr] : 0).
    - window[wptr] <= t; wptr increments modulo DEPTH.
    - fill++ saturating at DEPTH.
    - BestTime <= min(BestTime, t); WorstTime <= max(WorstTime, t). Equal values leave both unchanged.
    - TrialCount++ (saturating).
    - Next state: DIVIDE.
  - DIVIDE (exactly SUM_W cycles), Busy = 1:
    - Restoring divide, one quotient bit per cycle, MSB first.
    - Quotient = SUM / fill; truncates unless the rounding option is enabled.
  - DONE (1 cycle), Busy = 1: AvgTime <= quotient low TIME_W bits; StatsValid = 1. Next state: IDLE.
- Latency: ResultValid is sampled at edge 0. StatsValid is high during the cycle following edge SUM_W + 2 (15 cycles at defaults). The next ResultValid is accepted the cycle after DONE.
- While Busy, ResultValid of any kind is ignored (counters included) and Overrun <= 1. Only Rst or Clear clears Overrun.
- The quotient is always <= 2**TIME_W - 1, so no overflow. Fill is never 0 in DIVIDE.
- ResultTime = all ones is accepted as a normal value.
- Outputs are registered. Best, Worst and TrialCount update at the end of UPDATE, before StatsValid; consumers must sample on StatsValid.

Optional Feature:
- Macro: REACTION_STATS_ROUND_EN.
- Defined: the dividend is SUM + (fill >> 1), giving round-half-up. The divider dividend is SUM_W + 1 bits wide and DIVIDE lasts SUM_W + 1 cycles, so latency grows by 1.
- Undefined: truncating divide with the latency stated above.

Test Plan:
- Rst, then valid trials 200, 300, 250 (each separated by 20 cycles) -> AvgTime 200, 250, 250 at each StatsValid; final BestTime 200, WorstTime 300, TrialCount 3.
- Single valid trial 500 -> StatsValid pulses exactly 15 cycles after ResultValid, Busy high for 15 cycles, AvgTime 500.
- Cheat strobe with time 0, then a Slow strobe -> CheatCount 1, SlowCount 1, no StatsValid, BestTime 1023, TrialCount 0.
- Eight trials of 100, then one of 900 (DEPTH 8) -> AvgTime 200, BestTime 100, WorstTime 900, TrialCount 9.
- ResultValid 5 cycles after an accepted trial -> ignored, Overrun 1, TrialCount +1 only. Clear asserted mid-DIVIDE -> next cycle all outputs at reset values, no StatsValid.
- Trials 100, 101 -> AvgTime 100 without REACTION_STATS_ROUND_EN; 101 with it, StatsValid at 16 cycles.
